// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - register map and frame FSM state for the inertial sensor SPI responder
package inert_pkg;

    // Read/write configuration registers
    localparam logic [6:0] ADDR_INT_CFG  = 7'h0D;
    localparam logic [6:0] ADDR_CFG_10   = 7'h10;
    localparam logic [6:0] ADDR_CFG_11   = 7'h11;
    localparam logic [6:0] ADDR_CFG_14   = 7'h14;

    // Read-only identity register
    localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;

    // Read-only latched sample registers (low byte at the even address)
    localparam logic [6:0] ADDR_ROLL_L   = 7'h24;
    localparam logic [6:0] ADDR_ROLL_H   = 7'h25;
    localparam logic [6:0] ADDR_YAW_L    = 7'h26;
    localparam logic [6:0] ADDR_YAW_H    = 7'h27;
    localparam logic [6:0] ADDR_AY_L     = 7'h2A;
    localparam logic [6:0] ADDR_AY_H     = 7'h2B;
    localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
    localparam logic [6:0] ADDR_AZ_H     = 7'h2D;

    // INT_CFG bit that lets a new sample raise INT
    localparam int unsigned INT_EN_BIT   = 1;

    // SCLK rises in a complete frame
    localparam logic [4:0]  FRAME_RISES  = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_resp_shft.sv
// rtl/spi_resp_shft.sv - SPI pin synchronizers, frame FSM and rx/tx shift registers
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI      raw SPI pins from the master (asynchronous to clk)
//   MISO                  serial read data, forced low while SS_n is high
//   rdata                 read data for addr, loaded into tx while addr_vld
//   addr_vld              command byte complete; addr is the address being read
//   addr                  frame address (from rx[6:0] in CMD, rx[14:8] afterwards)
//   frame_done            one-clk pulse when the frame ends (DONE state)
//   frame_ok              frame had exactly 16 SCLK rises
//   frame_rd              R/W flag of the frame (1 = read)
//   wdata                 data byte of the frame
module spi_resp_shft
    import inert_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic [7:0] rdata,
    output logic       MISO,
    output logic       addr_vld,
    output logic [6:0] addr,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_rd,
    output logic [7:0] wdata
);

    // Bit 0 is the first synchronizer stage; bit 2 is the edge-detect history flop.
    logic [2:0]  ss_sync_q,   ss_sync_d;
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    state_t      state_q,     state_d;
    logic [15:0] rx_q,        rx_d;
    logic [7:0]  tx_q,        tx_d;
    logic [4:0]  cnt_q,       cnt_d;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_fall   =  ss_sync_q[2]   & ~ss_sync_q[1];
    assign ss_rise   = ~ss_sync_q[2]   &  ss_sync_q[1];
    assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];

    assign addr_vld   = (state_q == CMD) && (cnt_q == 5'd8);
    assign addr       = (state_q == CMD) ? rx_q[6:0] : rx_q[14:8];
    assign frame_rd   = rx_q[15];
    assign wdata      = rx_q[7:0];
    assign frame_done = (state_q == DONE);
    assign frame_ok   = (cnt_q == FRAME_RISES);
    assign MISO       = ~ss_sync_q[1] & tx_q[7];

    always_comb begin
        ss_sync_d   = {ss_sync_q[1:0], SS_n};
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
        state_d     = state_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        cnt_d       = cnt_q;

        if (ss_rise) begin
            state_d = DONE;
        end else if (ss_fall && (state_q != DATA)) begin
            state_d = CMD;
            rx_d    = '0;
            tx_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CMD: begin
                    if (addr_vld) begin
                        state_d = DATA;
                        tx_d    = rdata;
                    end else if (sclk_rise) begin
                        rx_d  = {rx_q[14:0], mosi_sync_q[1]};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[14:0], mosi_sync_q[1]};
                        // Saturate so an over-long frame can never wrap back to 16.
                        if (cnt_q != 5'd31) begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else if (sclk_fall && (cnt_q >= 5'd9)) begin
                        // No shift on fall9 so bit7 stays valid through rise9.
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    // Clear tx so MISO cannot glitch high as the next frame's SS_n falls.
                    tx_d    = '0;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b111;
            mosi_sync_q <= 2'b00;
            state_q     <= IDLE;
            rx_q        <= '0;
            tx_q        <= '0;
            cnt_q       <= '0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/inert_spi_resp.sv
// rtl/inert_spi_resp.sv - inertial sensor SPI responder: register file, sample latch and INT
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI, MISO     SPI responder pins (16-bit frames, MSB first)
//   INT                        new-sample-ready interrupt, cleared by a read of INT_CLR_ADDR
//   smpl                       one-clk strobe qualifying roll_rt/yaw_rt/AY/AZ
//   roll_rt, yaw_rt, AY, AZ    16-bit sample inputs
//   ovr                        sticky flag: a sample arrived while the previous one was unread
module inert_spi_resp
    import inert_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I     = 8'h6A,
    parameter logic [6:0] INT_CLR_ADDR = 7'h2D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        smpl,
    input  logic [15:0] roll_rt,
    input  logic [15:0] yaw_rt,
    input  logic [15:0] AY,
    input  logic [15:0] AZ,
    output logic        ovr
);

    logic       addr_vld, frame_done, frame_ok, frame_rd;
    logic [6:0] addr;
    logic [7:0] wdata, reg_rdata, rdata;

    logic [7:0]  int_cfg_q, int_cfg_d;
    logic [7:0]  cfg10_q,   cfg10_d;
    logic [7:0]  cfg11_q,   cfg11_d;
    logic [7:0]  cfg14_q,   cfg14_d;
    logic [15:0] roll_q,    roll_d;
    logic [15:0] yaw_q,     yaw_d;
    logic [15:0] ay_q,      ay_d;
    logic [15:0] az_q,      az_d;
    logic        int_q,     int_d;
    logic        ovr_q,     ovr_d;

    logic wr_en, int_clr, smpl_take;

    spi_resp_shft u_shft (
        .clk        (clk),
        .rst_n      (rst_n),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .rdata      (rdata),
        .MISO       (MISO),
        .addr_vld   (addr_vld),
        .addr       (addr),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_rd   (frame_rd),
        .wdata      (wdata)
    );

    always_comb begin
        reg_rdata = 8'h00;
        case (addr)
            ADDR_INT_CFG:  reg_rdata = int_cfg_q;
            ADDR_CFG_10:   reg_rdata = cfg10_q;
            ADDR_CFG_11:   reg_rdata = cfg11_q;
            ADDR_CFG_14:   reg_rdata = cfg14_q;
            ADDR_WHO_AM_I: reg_rdata = WHO_AM_I;
            ADDR_ROLL_L:   reg_rdata = roll_q[7:0];
            ADDR_ROLL_H:   reg_rdata = roll_q[15:8];
            ADDR_YAW_L:    reg_rdata = yaw_q[7:0];
            ADDR_YAW_H:    reg_rdata = yaw_q[15:8];
            ADDR_AY_L:     reg_rdata = ay_q[7:0];
            ADDR_AY_H:     reg_rdata = ay_q[15:8];
            ADDR_AZ_L:     reg_rdata = az_q[7:0];
            ADDR_AZ_H:     reg_rdata = az_q[15:8];
            default:       reg_rdata = 8'h00;
        endcase
    end

    // The shifter only consumes read data on the addr_vld cycle.
    assign rdata = addr_vld ? reg_rdata : 8'h00;

    assign wr_en   = frame_done & frame_ok & ~frame_rd;
    assign int_clr = frame_done & frame_ok &  frame_rd & (addr == INT_CLR_ADDR);
    // A pending (or just-cleared) sample blocks new ones so a burst read is never torn.
    assign smpl_take = smpl & ~int_q & ~int_clr;

    always_comb begin
        int_cfg_d = int_cfg_q;
        cfg10_d   = cfg10_q;
        cfg11_d   = cfg11_q;
        cfg14_d   = cfg14_q;
        roll_d    = roll_q;
        yaw_d     = yaw_q;
        ay_d      = ay_q;
        az_d      = az_q;
        int_d     = int_q;
        ovr_d     = ovr_q | (smpl & ~smpl_take);

        if (wr_en) begin
            case (addr)
                ADDR_INT_CFG: int_cfg_d = wdata;
                ADDR_CFG_10:  cfg10_d   = wdata;
                ADDR_CFG_11:  cfg11_d   = wdata;
                ADDR_CFG_14:  cfg14_d   = wdata;
                default: ;
            endcase
        end

        if (smpl_take) begin
            roll_d = roll_rt;
            yaw_d  = yaw_rt;
            ay_d   = AY;
            az_d   = AZ;
        end

        if (int_clr) begin
            int_d = 1'b0;
        end else if (smpl_take) begin
            int_d = int_cfg_q[INT_EN_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cfg_q <= '0;
            cfg10_q   <= '0;
            cfg11_q   <= '0;
            cfg14_q   <= '0;
            roll_q    <= '0;
            yaw_q     <= '0;
            ay_q      <= '0;
            az_q      <= '0;
            int_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            int_cfg_q <= int_cfg_d;
            cfg10_q   <= cfg10_d;
            cfg11_q   <= cfg11_d;
            cfg14_q   <= cfg14_d;
            roll_q    <= roll_d;
            yaw_q     <= yaw_d;
            ay_q      <= ay_d;
            az_q      <= az_d;
            int_q     <= int_d;
            ovr_q     <= ovr_d;
        end
    end

    assign INT = int_q;
    assign ovr = ovr_q;

endmodule
